// File: rtl/spi_controller.sv
// spi_controller: single-byte full-duplex SPI mode-0 master, MSB first, SCLK = clk/(2*CLK_DIV).
// Define SPI_ERROR_EN to get a sticky o_error for requests dropped while busy; otherwise o_error is 0.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_cipo,
  output logic       o_copi,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic       o_error
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  localparam logic [7:0] TC = 8'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, rx_q, rx_d, data_q, data_d;
  logic [6:0] tx_q, tx_d;
  logic [2:0] bit_q, bit_d;
  logic       sclk_q, sclk_d, copi_q, copi_d, cs_n_q, cs_n_d, valid_q, valid_d;
  logic       tc;

  assign tc = (cnt_q == TC);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    cs_n_d  = cs_n_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (i_valid) begin
        tx_d    = i_data[6:0];
        rx_d    = '0;
        copi_d  = i_data[7];
        cs_n_d  = 1'b0;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = SETUP;
      end
      SETUP: if (tc) begin
        // first rising SCLK edge: capture bit 7 from the peripheral
        cnt_d   = '0;
        sclk_d  = 1'b1;
        rx_d    = {rx_q[6:0], i_cipo};
        state_d = SHIFT;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      SHIFT: if (tc) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          rx_d = {rx_q[6:0], i_cipo};
        end else if (bit_q == 3'd7) begin
          state_d = HOLD;
        end else begin
          copi_d = tx_q[6];
          tx_d   = {tx_q[5:0], 1'b0};
          bit_d  = bit_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      HOLD: if (tc) begin
        cnt_d   = '0;
        cs_n_d  = 1'b1;
        copi_d  = 1'b0;
        data_d  = rx_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      cs_n_q  <= cs_n_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_copi  = copi_q;
  assign o_sclk  = sclk_q;
  assign o_cs_n  = cs_n_q;

`ifdef SPI_ERROR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (i_valid & ~o_ready);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign o_error = err_q;
`else
  assign o_error = 1'b0;
`endif

endmodule
